// File: rtl/microwave_sequencer_pkg.sv
// Shared types and constants for the microwave cycle sequencer:
// FSM state encoding, BCD digit width and the per-digit decrement helper.
package microwave_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_NINE     = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Returns {borrow, new_digit}; a zero digit wraps to wrap_val and borrows.
    function automatic logic [BCD_W:0] bcd_digit_dec(input logic [BCD_W-1:0] digit,
                                                     input logic [BCD_W-1:0] wrap_val);
        logic [BCD_W:0] result;
        if (digit == {BCD_W{1'b0}}) begin
            result = {1'b1, wrap_val};
        end else begin
            result = {1'b0, digit - 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/microwave_sequencer_if.sv
// Button/keypad/display bundle between the panel (master) and the sequencer (slave).
// The beep line exists only when MICROWAVE_BEEP_EN is defined.
interface microwave_sequencer_if;
    import microwave_pkg::*;

    logic             startn;
    logic             stopn;
    logic             clearn;
    logic             door_closed;
    logic             key_valid;
    logic [BCD_W-1:0] key_digit;
    logic             mag_on;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic [2:0]       state;
    logic             timer_done;
`ifdef MICROWAVE_BEEP_EN
    logic             beep;
`endif

    modport master (
        output startn, stopn, clearn, door_closed, key_valid, key_digit,
        input  mag_on, min_tens, min_ones, sec_tens, sec_ones, state, timer_done
`ifdef MICROWAVE_BEEP_EN
        , input beep
`endif
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, key_valid, key_digit,
        output mag_on, min_tens, min_ones, sec_tens, sec_ones, state, timer_done
`ifdef MICROWAVE_BEEP_EN
        , output beep
`endif
    );

endinterface

// File: rtl/microwave_sequencer_bcd_mmss_counter.sv
// Four-digit MM:SS BCD register: clear, keypad shift-in and borrow-chained decrement.
// Seconds tens wrap to 5, so raw entries such as 0:90 still count down one per tick.
module bcd_mmss_counter
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_dec,
    output logic [BCD_W-1:0] o_min_tens,
    output logic [BCD_W-1:0] o_min_ones,
    output logic [BCD_W-1:0] o_sec_tens,
    output logic [BCD_W-1:0] o_sec_ones,
    output logic             o_zero,
    output logic             o_last
);

    logic [BCD_W-1:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [BCD_W-1:0] w_min_tens_dec, w_min_ones_dec, w_sec_tens_dec, w_sec_ones_dec;
    logic             w_borrow_so, w_borrow_st, w_borrow_mo;

    assign {w_borrow_so, w_sec_ones_dec} = bcd_digit_dec(r_sec_ones, BCD_NINE);
    assign {w_borrow_st, w_sec_tens_dec} = w_borrow_so ? bcd_digit_dec(r_sec_tens, SEC_TENS_MAX)
                                                       : {1'b0, r_sec_tens};
    assign {w_borrow_mo, w_min_ones_dec} = w_borrow_st ? bcd_digit_dec(r_min_ones, BCD_NINE)
                                                       : {1'b0, r_min_ones};
    assign w_min_tens_dec = w_borrow_mo ? (r_min_tens - 4'd1) : r_min_tens;

    // Digit register: clear beats shift beats decrement.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else if (i_clr) begin
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else if (i_shift) begin
            r_min_tens <= r_min_ones;
            r_min_ones <= r_sec_tens;
            r_sec_tens <= r_sec_ones;
            r_sec_ones <= i_digit;
        end else if (i_dec) begin
            r_min_tens <= w_min_tens_dec;
            r_min_ones <= w_min_ones_dec;
            r_sec_tens <= w_sec_tens_dec;
            r_sec_ones <= w_sec_ones_dec;
        end else begin
            r_min_tens <= r_min_tens;
            r_min_ones <= r_min_ones;
            r_sec_tens <= r_sec_tens;
            r_sec_ones <= r_sec_ones;
        end
    end

    assign o_min_tens = r_min_tens;
    assign o_min_ones = r_min_ones;
    assign o_sec_tens = r_sec_tens;
    assign o_sec_ones = r_sec_ones;
    assign o_zero = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0000);
    assign o_last = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0001);

endmodule

// File: rtl/microwave_sequencer.sv
// Microwave cooking sequencer: button edge detection, cooking FSM, tick prescaler.
// Define MICROWAVE_BEEP_EN to add the end-of-cycle beep output and its tick counter.
module microwave_sequencer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100
`ifdef MICROWAVE_BEEP_EN
    ,
    parameter int BEEP_SECS = 3
`endif
) (
    input logic                 clk,
    input logic                 resetn,
    microwave_sequencer_if.slave bus
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    state_e             r_state, w_state_nxt;
    logic               r_startn_q, r_stopn_q, r_clearn_q, r_door_q;
    logic [PRESC_W-1:0] r_presc;
    logic               r_timer_done;
    logic               w_start_ev, w_stop_ev, w_clear_ev, w_door_open_ev, w_key_ok;
    logic               w_tick, w_clr, w_shift, w_dec, w_done_nxt, w_presc_run, w_presc_clr;
    logic               w_zero, w_last;
    logic [BCD_W-1:0]   w_min_tens, w_min_ones, w_sec_tens, w_sec_ones;

    assign w_start_ev     = r_startn_q  & ~bus.startn;
    assign w_stop_ev      = r_stopn_q   & ~bus.stopn;
    assign w_clear_ev     = r_clearn_q  & ~bus.clearn;
    assign w_door_open_ev = r_door_q    & ~bus.door_closed;
    assign w_key_ok       = bus.key_valid && (bus.key_digit <= BCD_NINE);
    assign w_tick         = (r_presc == PRESC_LAST);
    assign w_presc_clr    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ENTRY);

    // Input history for press/door-open edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_startn_q <= 1'b1;
            r_stopn_q  <= 1'b1;
            r_clearn_q <= 1'b1;
            r_door_q   <= 1'b1;
        end else begin
            r_startn_q <= bus.startn;
            r_stopn_q  <= bus.stopn;
            r_clearn_q <= bus.clearn;
            r_door_q   <= bus.door_closed;
        end
    end

    // State, prescaler and done-pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_presc      <= {PRESC_W{1'b0}};
            r_timer_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer_done <= w_done_nxt;
            if (w_presc_clr) begin
                r_presc <= {PRESC_W{1'b0}};
            end else if (w_presc_run) begin
                r_presc <= w_tick ? {PRESC_W{1'b0}} : (r_presc + PRESC_W'(1));
            end else begin
                r_presc <= r_presc;
            end
        end
    end

    // Next-state and datapath controls; priority clear > stop > door > start > key.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift     = 1'b0;
        w_dec       = 1'b0;
        w_done_nxt  = 1'b0;
        w_presc_run = 1'b0;
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (w_clear_ev) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_stop_ev) begin
                    w_state_nxt = r_state;
                end else if (w_start_ev && bus.door_closed && !w_zero) begin
                    w_state_nxt = ST_COOK;
                end else if (w_key_ok) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_ENTRY;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_COOK: begin
                if (w_clear_ev) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_stop_ev || !bus.door_closed) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_presc_run = 1'b1;
                    w_dec       = w_tick;
                    if (w_tick && w_last) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_COOK;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_clear_ev || w_stop_ev) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_start_ev && bus.door_closed) begin
                    w_state_nxt = ST_COOK;
                end else begin
                    w_state_nxt = ST_PAUSE;
                end
            end
            ST_DONE: begin
`ifdef MICROWAVE_BEEP_EN
                w_presc_run = 1'b1;
`endif
                if (w_clear_ev || w_stop_ev || w_start_ev || w_door_open_ev) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_key_ok) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_ENTRY;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    bcd_mmss_counter u_counter (
        .clk        (clk),
        .resetn     (resetn),
        .i_clr      (w_clr),
        .i_shift    (w_shift),
        .i_digit    (bus.key_digit),
        .i_dec      (w_dec),
        .o_min_tens (w_min_tens),
        .o_min_ones (w_min_ones),
        .o_sec_tens (w_sec_tens),
        .o_sec_ones (w_sec_ones),
        .o_zero     (w_zero),
        .o_last     (w_last)
    );

`ifdef MICROWAVE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_SECS + 1);
    logic              r_beep;
    logic [BEEP_W-1:0] r_beep_cnt;

    // Alarm: set on entry to DONE, dropped after BEEP_SECS ticks or on leaving DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= {BEEP_W{1'b0}};
        end else if (w_state_nxt != ST_DONE) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= {BEEP_W{1'b0}};
        end else if (r_state != ST_DONE) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= {BEEP_W{1'b0}};
        end else if (r_beep && w_tick) begin
            if (r_beep_cnt == BEEP_W'(BEEP_SECS - 1)) begin
                r_beep <= 1'b0;
            end else begin
                r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
            end
        end else begin
            r_beep     <= r_beep;
            r_beep_cnt <= r_beep_cnt;
        end
    end

    assign bus.beep = r_beep;
`endif

    assign bus.mag_on     = (r_state == ST_COOK) && bus.door_closed;
    assign bus.state      = r_state;
    assign bus.timer_done = r_timer_done;
    assign bus.min_tens   = w_min_tens;
    assign bus.min_ones   = w_min_ones;
    assign bus.sec_tens   = w_sec_tens;
    assign bus.sec_ones   = w_sec_ones;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Scoreboard bench for microwave_sequencer: stimulus queues expected snapshots and
// timer_done cycles computed from the entered time; a monitor compares them on negedges.
module tb_microwave_sequencer;
    import microwave_pkg::*;

    localparam int TD      = 4;
    localparam int B_START = 1;
    localparam int B_STOP  = 2;
    localparam int B_CLEAR = 4;

    typedef struct {
        int          at;
        string       name;
        logic [15:0] disp;
        logic [2:0]  st;
        logic        mag;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   entered = 0;
    exp_t exp_q[$];
    int   done_q[$];

    microwave_sequencer_if mw();

    microwave_sequencer #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (mw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] disp_of(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Display after k ticks of an entry mm:ss where ss may be 60..99.
    function automatic logic [15:0] disp_after(input int mn, input int sc, input int k);
        int r;
        if (k <= sc) return disp_of(mn * 100 + sc - k);
        r = mn * 60 - (k - sc);
        return disp_of((r / 60) * 100 + (r % 60));
    endfunction

    task automatic expect_at(input int at, input string nm, input logic [15:0] d,
                             input logic [2:0] st, input logic mag);
        exp_t e;
        e.at = at; e.name = nm; e.disp = d; e.st = st; e.mag = mag;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, output int s);
        @(negedge clk);
        mw.startn = ((which & B_START) != 0) ? 1'b0 : 1'b1;
        mw.stopn  = ((which & B_STOP)  != 0) ? 1'b0 : 1'b1;
        mw.clearn = ((which & B_CLEAR) != 0) ? 1'b0 : 1'b1;
        s = cyc + 1;
        @(negedge clk);
        mw.startn = 1'b1;
        mw.stopn  = 1'b1;
        mw.clearn = 1'b1;
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk);
        mw.key_valid = 1'b1;
        mw.key_digit = d;
        @(negedge clk);
        mw.key_valid = 1'b0;
        if (d <= 4'd9) entered = (entered * 10 + int'(d)) % 10000;
    endtask

    task automatic cook_full(input string tag);
        int s, n, mn, sc, k1, k2;
        mn = entered / 100;
        sc = entered % 100;
        n  = mn * 60 + sc;
        press(B_START, s);
        expect_at(s, {tag, "_start"}, disp_of(entered), ST_COOK, 1'b1);
        if (n >= 3) begin
            k1 = $urandom_range(1, n / 2);
            k2 = $urandom_range(n / 2 + 1, n - 1);
            expect_at(s + k1 * TD, {tag, "_mid1"}, disp_after(mn, sc, k1), ST_COOK, 1'b1);
            expect_at(s + k2 * TD, {tag, "_mid2"}, disp_after(mn, sc, k2), ST_COOK, 1'b1);
        end
        done_q.push_back(s + n * TD);
        expect_at(s + n * TD, {tag, "_done"}, 16'h0000, ST_DONE, 1'b0);
        step(s + n * TD - cyc);
        entered = 0;
    endtask

    // Monitor: compares queued snapshots and the timer_done pulse one step after each negedge.
    always begin
        exp_t e;
        logic [15:0] act;
        @(negedge clk);
        #1;
        act = {mw.min_tens, mw.min_ones, mw.sec_tens, mw.sec_ones};
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.at != cyc)
                $display("FAIL %s: snapshot for cycle %0d not taken (now %0d)", e.name, e.at, cyc);
            else if (act === e.disp && mw.state === e.st && mw.mag_on === e.mag)
                passes++;
            else
                $display("FAIL %s: got disp=%h state=%0d mag=%b, want disp=%h state=%0d mag=%b",
                         e.name, act, mw.state, mw.mag_on, e.disp, e.st, e.mag);
        end
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            void'(done_q.pop_front());
            checks++;
            if (mw.timer_done === 1'b1) passes++;
            else $display("FAIL timer_done_pulse: got %b at cycle %0d, want 1", mw.timer_done, cyc);
        end else if (mw.timer_done !== 1'b0) begin
            checks++;
            $display("FAIL timer_done_spurious: got %b at cycle %0d, want 0", mw.timer_done, cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

    initial begin
        int s, s2, o, phase, r;
        logic [3:0] d;
        mw.startn = 1'b1; mw.stopn = 1'b1; mw.clearn = 1'b1;
        mw.door_closed = 1'b1; mw.key_valid = 1'b0; mw.key_digit = 4'd0;
        step(2);
        expect_at(cyc, "reset_state", 16'h0000, ST_IDLE, 1'b0);
        step(1);
        resetn = 1'b1;
        step(1);

        // Entry 1,3,0 then a full 90-tick cook.
        key(4'd1);  expect_at(cyc, "key1", disp_of(entered), ST_ENTRY, 1'b0);
        key(4'd3);  expect_at(cyc, "key3", disp_of(entered), ST_ENTRY, 1'b0);
        key(4'd0);  expect_at(cyc, "key0", disp_of(entered), ST_ENTRY, 1'b0);
        key(4'd12); expect_at(cyc, "key_gt9_ignored", 16'h0130, ST_ENTRY, 1'b0);
        cook_full("cook_0130");
        step(1);
        expect_at(cyc, "done_hold", 16'h0000, ST_DONE, 1'b0);
        key(4'd4);  expect_at(cyc, "done_key", 16'h0004, ST_ENTRY, 1'b0);

        // Start guards.
        press(B_CLEAR, s); entered = 0;
        expect_at(cyc, "clear_entry", 16'h0000, ST_IDLE, 1'b0);
        press(B_START, s);
        expect_at(cyc, "start_zero_ignored", 16'h0000, ST_IDLE, 1'b0);
        key(4'd1); key(4'd0);
        expect_at(cyc, "entry_0010", 16'h0010, ST_ENTRY, 1'b0);
        @(negedge clk); mw.door_closed = 1'b0;
        press(B_START, s);
        expect_at(cyc, "start_door_open_ignored", 16'h0010, ST_ENTRY, 1'b0);
        mw.door_closed = 1'b1;
        step(1);

        // Door pause at 00:07 with one prescaler cycle already counted, then resume.
        press(B_START, s);
        expect_at(s + 3 * TD, "cook_0007", 16'h0007, ST_COOK, 1'b1);
        o = s + 3 * TD + 1;
        phase = o - (s + 3 * TD);
        step(o - cyc);
        mw.door_closed = 1'b0;
        expect_at(cyc, "door_mag_drop", 16'h0007, ST_COOK, 1'b0);
        step(1);
        expect_at(cyc, "door_pause", 16'h0007, ST_PAUSE, 1'b0);
        step(3 * TD);
        expect_at(cyc, "pause_hold", 16'h0007, ST_PAUSE, 1'b0);
        mw.door_closed = 1'b1;
        step(1);
        press(B_START, s2);
        expect_at(s2, "resume", 16'h0007, ST_COOK, 1'b1);
        done_q.push_back(s2 + 7 * TD - phase);
        expect_at(s2 + 7 * TD - phase, "resume_done", 16'h0000, ST_DONE, 1'b0);
        step(s2 + 7 * TD - phase - cyc);
        entered = 0;
        press(B_STOP, s);
        expect_at(cyc, "done_stop", 16'h0000, ST_IDLE, 1'b0);

        // Wrap-around decrements.
        key(4'd1); key(4'd0); key(4'd0);
        press(B_START, s);
        expect_at(s + TD, "wrap_0100", 16'h0059, ST_COOK, 1'b1);
        step(TD);
        press(B_CLEAR, s); entered = 0;
        expect_at(cyc, "cook_clear", 16'h0000, ST_IDLE, 1'b0);
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        press(B_START, s);
        expect_at(s + TD, "wrap_1000", 16'h0959, ST_COOK, 1'b1);
        step(TD);
        press(B_STOP, s);
        expect_at(cyc, "cook_stop", 16'h0959, ST_PAUSE, 1'b0);
        press(B_START | B_STOP, s); entered = 0;
        expect_at(cyc, "pause_start_stop", 16'h0000, ST_IDLE, 1'b0);

        // Clear and key in the same cycle.
        key(4'd1); key(4'd2);
        @(negedge clk);
        mw.clearn = 1'b0; mw.key_valid = 1'b1; mw.key_digit = 4'd7;
        @(negedge clk);
        mw.clearn = 1'b1; mw.key_valid = 1'b0; entered = 0;
        expect_at(cyc, "clear_and_key", 16'h0000, ST_IDLE, 1'b0);

        // Randomized entries and DONE exits.
        for (int it = 0; it < 6; it++) begin
            press(B_CLEAR, s); entered = 0;
            expect_at(cyc, "rnd_clear", 16'h0000, ST_IDLE, 1'b0);
            for (int j = 0; j < int'($urandom_range(1, 2)); j++) key(4'($urandom_range(0, 9)));
            if (entered == 0) key(4'd1);
            expect_at(cyc, "rnd_entry", disp_of(entered), ST_ENTRY, 1'b0);
            cook_full("rnd_cook");
            r = $urandom_range(0, 4);
            if (r <= 2) begin
                press((r == 0) ? B_START : ((r == 1) ? B_STOP : B_CLEAR), s);
                expect_at(cyc, "rnd_exit_button", 16'h0000, ST_IDLE, 1'b0);
            end else if (r == 3) begin
                @(negedge clk); mw.door_closed = 1'b0;
                @(negedge clk);
                expect_at(cyc, "rnd_exit_door", 16'h0000, ST_IDLE, 1'b0);
                mw.door_closed = 1'b1;
            end else begin
                d = 4'($urandom_range(1, 9));
                key(d);
                expect_at(cyc, "rnd_exit_key", disp_of(entered), ST_ENTRY, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a cook at 00:42.
        press(B_CLEAR, s); entered = 0;
        key(4'd4); key(4'd5);
        press(B_START, s);
        expect_at(s + 3 * TD, "cook_0042", 16'h0042, ST_COOK, 1'b1);
        step(s + 3 * TD + 1 - cyc);
        resetn = 1'b0;
        entered = 0;
        expect_at(cyc, "reset_mid_cook", 16'h0000, ST_IDLE, 1'b0);
        step(2);
        resetn = 1'b1;
        step(1);
        expect_at(cyc, "after_reset", 16'h0000, ST_IDLE, 1'b0);
        step(3);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s: snapshot for cycle %0d never compared", e.name, e.at);
        end
        while (done_q.size() > 0) begin
            checks++;
            $display("FAIL timer_done_missing: expected pulse at cycle %0d", done_q.pop_front());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/microwave_sequencer.md
# microwave_sequencer

Cycle sequencer for the microwave oven controller. It captures keypad time entry, runs the MM:SS BCD countdown and drives the magnetron enable. It replaces the free-running timer that feeds `timer_done` into the start/stop latch logic, and owns the cooking state machine. All button inputs are active-low levels, already debounced and synchronous to `clk`.

## Interface
- `TICK_DIV`, 100 — `clk` cycles per one-second countdown tick (≥2)
- `BEEP_SECS`, 3 — duration of the end-of-cycle alarm, in ticks (only with `MICROWAVE_BEEP_EN`)

- `clk` in 1 — system clock, rising edge
- `resetn` in 1 — reset; one clock; asynchronous, active-low
- `startn` in 1 — start button, active-low level
- `stopn` in 1 — stop button, active-low level
- `clearn` in 1 — clear button, active-low level
- `door_closed` in 1 — 1 = door closed
- `key_valid` in 1 — one-cycle strobe, keypad digit present
- `key_digit` in 4 — BCD digit; values >9 are ignored
- `mag_on` out 1 — magnetron enable
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` out 4 each — BCD display of the remaining/entered time
- `state` out 3 — current FSM state encoding
- `timer_done` out 1 — one-cycle pulse when the countdown reaches 00:00
- `beep` out 1 — alarm output (only with `MICROWAVE_BEEP_EN`)

## Operation
- **Button events.** A press is the falling edge of the registered level (previous 1, current 0). Holding a button generates one event only.
- **States:** IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.
- **Priority within one cycle:** clear > stop > door open > start > key.
- **IDLE/ENTRY:**
  - A valid key shifts the digits left: `min_tens`←`min_ones`←`sec_tens`←`sec_ones`←`key_digit`. The state becomes ENTRY.
  - Start with the door closed and time ≠ 0 → COOK. Start with time = 0 or the door open is ignored.
  - Clear zeroes all digits → IDLE.
- **COOK:**
  - `mag_on = (state==COOK) & door_closed`. This is combinational, so the enable drops in the same cycle the door opens.
  - The prescaler counts 0..`TICK_DIV`-1. At terminal count the time decrements.
  - Decrement rule: `sec_ones` 0→9 with borrow into `sec_tens`. Seconds 00 → 59 with borrow into minutes. Minutes follow the same rule (`min_ones` 0→9, `min_tens` decrements).
  - Raw entered seconds 60–99 count down normally (e.g. 0:90 lasts 90 ticks).
  - Reaching 00:00 → DONE, and `timer_done` pulses for 1 cycle.
  - Door open or stop → PAUSE. Clear → IDLE with the time zeroed.
  - Keys are ignored.
- **PAUSE:**
  - The prescaler and time hold.
  - Start with the door closed → COOK, and the prescaler resumes from its held value.
  - Stop or clear → IDLE with the time zeroed.
- **DONE:**
  - The time reads 00:00.
  - Any button press or a door-open event → IDLE.
  - A valid key → ENTRY with that digit loaded.
- **Reset:** state IDLE, all digits 0, prescaler 0, `mag_on`=0, `timer_done`=0, `beep`=0, button history registers 1. Reset asserted mid-cook stops the magnetron immediately, because it is asynchronous.

## Timing
- A start press sampled at edge N puts `state`=COOK after edge N. `mag_on` is high from then on.
- The first decrement happens `TICK_DIV` cycles after entering COOK from zero.
- The last tick moves to DONE on the same edge that writes 00:00. `timer_done` is high for exactly the following cycle.
- The display is registered and updates on the edge after a key strobe or a tick.

## Configuration
- `MICROWAVE_BEEP_EN` defined: `beep`=1 on entering DONE, held for `BEEP_SECS` ticks. The prescaler keeps running in DONE for this purpose. Leaving DONE early clears `beep` on the next edge.
- `MICROWAVE_BEEP_EN` not defined: the `beep` port, the `BEEP_SECS` counter and the DONE-state prescaler activity are absent.

## Structure
- **Package `microwave_pkg`:** state encodings (IDLE..DONE), BCD digit width 4, constants `BCD_NINE`=9 and `SEC_TENS_MAX`=5.
- **Sub-module `bcd_mmss_counter`:** the four-digit load/shift/decrement register with a zero flag. The FSM, prescaler and button edge detection stay in the top module.

## Test plan
- **Entry and start.** Keys 1,3,0 then start with the door closed → display 01:30, COOK, `mag_on`=1. After 90×`TICK_DIV` cycles → 00:00, `timer_done` pulse, DONE.
- **Start guards.** Start with time 00:00, or with the door open and 00:10 → state stays IDLE/ENTRY, `mag_on`=0.
- **Door pause/resume.** Open the door at 00:07 → `mag_on`=0 in the same cycle, PAUSE, time held at 00:07 for 3×`TICK_DIV` cycles. Close the door and press start → COOK, ends after the remaining ticks.
- **Wrap-around.** Load 01:00 and run 1 tick → 00:59. Load 10:00 → 09:59.
- **Simultaneous press.** Start and stop fall in the same cycle in PAUSE → IDLE, time 00:00. Clear and key in the same cycle → display 00:00.
- **Reset mid-cook.** `resetn`=0 during COOK at 00:42 → `mag_on`=0 and all digits 0 without waiting for a clock edge, state IDLE.
